// File: rtl/fifo_umbral.sv
// Synchronous FIFO with sticky overflow/underflow error and programmable
// almost-full / almost-empty levels taken live from the threshold inputs.
module fifo_umbral #(
    parameter int unsigned WORD_SIZE = 12,
    parameter int unsigned MEM_SIZE  = 8,
    parameter int unsigned PTR       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_enable,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 rd_enable,
    input  logic [PTR-1:0]       full_threshold,
    input  logic [PTR-1:0]       empty_threshold,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error
);

    localparam int unsigned      CNT_W = PTR + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MEM_SIZE);
    localparam logic [PTR-1:0]   LAST  = PTR'(MEM_SIZE - 1);

    logic [WORD_SIZE-1:0] mem [MEM_SIZE];
    logic [PTR-1:0]       wr_ptr;
    logic [PTR-1:0]       rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 reject;

    function automatic logic [PTR-1:0] ptr_inc(input logic [PTR-1:0] p);
        return (p == LAST) ? '0 : p + PTR'(1);
    endfunction

    // Status flags follow count and the live thresholds with no latching.
    always_comb begin
        fifo_empty   = (count == '0);
        fifo_full    = (count == DEPTH);
        almost_full  = (count >= {1'b0, full_threshold});
        almost_empty = (count <= {1'b0, empty_threshold});
    end

    // A write into a full FIFO is still taken when a read frees a slot on the same edge.
    always_comb begin
        rd_ok  = rd_enable && !fifo_empty;
        wr_ok  = wr_enable && (!fifo_full || rd_ok);
        reject = (wr_enable && !wr_ok) || (rd_enable && !rd_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid_out <= rd_ok;
            if (rd_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= ptr_inc(rd_ptr);
            end
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (reject) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed self-checking bench for fifo_umbral; a small queue model tracks
// expected contents alongside hand-computed checkpoints.
module tb_fifo_umbral;

    logic        clk;
    logic        reset;
    logic        wr_enable;
    logic [11:0] data_in;
    logic        rd_enable;
    logic [2:0]  full_threshold;
    logic [2:0]  empty_threshold;
    logic [11:0] data_out;
    logic        valid_out;
    logic        fifo_empty;
    logic        fifo_full;
    logic        almost_full;
    logic        almost_empty;
    logic        error;

    int n_tests;
    int n_fail;

    logic [11:0] model_q[$];
    logic [11:0] exp_data;
    logic        exp_valid;
    logic        exp_err;

    fifo_umbral #(.WORD_SIZE(12), .MEM_SIZE(8), .PTR(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_enable       (wr_enable),
        .data_in         (data_in),
        .rd_enable       (rd_enable),
        .full_threshold  (full_threshold),
        .empty_threshold (empty_threshold),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".valid"}, 32'(valid_out), 32'(exp_valid));
        check({tag, ".data"}, 32'(data_out), 32'(exp_data));
        check({tag, ".count"}, 32'(dut.count), 32'(sz));
        check({tag, ".empty"}, 32'(fifo_empty), 32'(sz == 0));
        check({tag, ".full"}, 32'(fifo_full), 32'(sz == 8));
        check({tag, ".afull"}, 32'(almost_full), 32'(sz >= int'(full_threshold)));
        check({tag, ".aempty"}, 32'(almost_empty), 32'(sz <= int'(empty_threshold)));
        check({tag, ".error"}, 32'(error), 32'(exp_err));
    endtask

    // One clock with the given request pattern; the model decides acceptance.
    task automatic cyc(input string tag, input logic w, input logic r, input logic [11:0] d);
        logic rd_ok;
        logic wr_ok;
        wr_enable = w;
        rd_enable = r;
        data_in   = d;
        rd_ok = r && (model_q.size() > 0);
        wr_ok = w && ((model_q.size() < 8) || rd_ok);
        tick();
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        exp_valid = rd_ok;
        if (rd_ok) exp_data = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        if ((w && !wr_ok) || (r && !rd_ok)) exp_err = 1'b1;
        check_state(tag);
    endtask

    // Reset with both requests high to confirm reset wins.
    task automatic do_reset(input string tag);
        reset     = 1'b1;
        wr_enable = 1'b1;
        rd_enable = 1'b1;
        data_in   = 12'hFFF;
        tick();
        reset     = 1'b0;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        model_q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        check_state(tag);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        data_in = '0;
        full_threshold  = 3'd6;
        empty_threshold = 3'd1;
        exp_data = '0;
        exp_valid = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset("rst");
        check("rst.empty_hand", 32'(fifo_empty), 32'd1);
        check("rst.full_hand", 32'(fifo_full), 32'd0);
        check("rst.aempty_hand", 32'(almost_empty), 32'd1);
        check("rst.wr_ptr", 32'(dut.wr_ptr), 32'd0);
        check("rst.rd_ptr", 32'(dut.rd_ptr), 32'd0);

        // Full-threshold zero keeps almost_full high even when empty
        full_threshold = 3'd0;
        #1;
        check("th0.afull_empty", 32'(almost_full), 32'd1);
        full_threshold = 3'd6;
        #1;

        // Fill with 0x000..0x007, then drain in order
        for (int i = 0; i < 8; i++) cyc("fill", 1'b1, 1'b0, 12'(i));
        check("fill.count8", 32'(dut.count), 32'd8);
        check("fill.full", 32'(fifo_full), 32'd1);
        check("fill.err", 32'(error), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc("drain", 1'b0, 1'b1, 12'h0);
            check("drain.data_hand", 32'(data_out), 32'(i));
            check("drain.valid_hand", 32'(valid_out), 32'd1);
        end
        cyc("idle", 1'b0, 1'b0, 12'h0);
        check("idle.hold", 32'(data_out), 32'h007);
        check("idle.valid", 32'(valid_out), 32'd0);

        // Thresholds 6/1
        for (int i = 0; i < 6; i++) begin
            cyc("thw", 1'b1, 1'b0, 12'(12'h100 + i));
            if (i == 4) check("thw.afull_at5", 32'(almost_full), 32'd0);
        end
        check("thw.afull_at6", 32'(almost_full), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc("thr", 1'b0, 1'b1, 12'h0);
            if (i == 3) check("thr.aempty_at2", 32'(almost_empty), 32'd0);
        end
        check("thr.data_hand", 32'(data_out), 32'h104);
        check("thr.aempty_at1", 32'(almost_empty), 32'd1);
        full_threshold  = 3'b010;
        empty_threshold = 3'b100;
        #1;
        check("thchg.afull", 32'(almost_full), 32'd0);
        check("thchg.aempty", 32'(almost_empty), 32'd1);
        empty_threshold = 3'd0;
        #1;
        check("th0.aempty_cnt1", 32'(almost_empty), 32'd0);
        check("th0.empty_cnt1", 32'(fifo_empty), 32'd0);
        cyc("th0.last", 1'b0, 1'b1, 12'h0);
        check("th0.last_data", 32'(data_out), 32'h105);
        check("th0.aempty_cnt0", 32'(almost_empty), 32'd1);
        full_threshold  = 3'd6;
        empty_threshold = 3'd1;
        #1;

        // Overflow: 0xABC dropped
        for (int i = 0; i < 8; i++) cyc("ovf.fill", 1'b1, 1'b0, 12'(12'h200 + i));
        cyc("ovf.push", 1'b1, 1'b0, 12'hABC);
        check("ovf.err", 32'(error), 32'd1);
        check("ovf.count", 32'(dut.count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cyc("ovf.drain", 1'b0, 1'b1, 12'h0);
            check("ovf.data_hand", 32'(data_out), 32'(12'h200 + i));
        end
        check("ovf.empty_after", 32'(fifo_empty), 32'd1);
        do_reset("rst2");

        // Empty with simultaneous read/write: no fall-through
        cyc("efall", 1'b1, 1'b1, 12'h055);
        check("efall.count", 32'(dut.count), 32'd1);
        check("efall.valid", 32'(valid_out), 32'd0);
        check("efall.err", 32'(error), 32'd1);
        do_reset("rst3");

        // Full with simultaneous read/write for 10 cycles
        for (int i = 0; i < 8; i++) cyc("rw.fill", 1'b1, 1'b0, 12'(12'h300 + i));
        for (int k = 0; k < 10; k++) begin
            cyc("rw", 1'b1, 1'b1, 12'(12'h310 + k));
            check("rw.full", 32'(fifo_full), 32'd1);
        end
        check("rw.last_data", 32'(data_out), 32'h311);
        check("rw.wr_ptr", 32'(dut.wr_ptr), 32'd2);
        check("rw.rd_ptr", 32'(dut.rd_ptr), 32'd2);
        check("rw.err", 32'(error), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc("rw.drain", 1'b0, 1'b1, 12'h0);
            check("rw.drain_hand", 32'(data_out), 32'(12'h312 + i));
        end

        // Underflow, then reset mid-operation with 5 words stored
        cyc("unf", 1'b0, 1'b1, 12'h0);
        check("unf.err", 32'(error), 32'd1);
        for (int i = 0; i < 5; i++) cyc("mid.fill", 1'b1, 1'b0, 12'(12'h400 + i));
        cyc("mid.read", 1'b0, 1'b1, 12'h0);
        cyc("mid.fill6", 1'b1, 1'b0, 12'h405);
        check("mid.count5", 32'(dut.count), 32'd5);
        do_reset("mid.rst");
        check("mid.count0", 32'(dut.count), 32'd0);
        check("mid.empty", 32'(fifo_empty), 32'd1);
        check("mid.err0", 32'(error), 32'd0);
        check("mid.valid0", 32'(valid_out), 32'd0);
        cyc("mid.post_rd", 1'b0, 1'b1, 12'h0);
        check("mid.discard", 32'(valid_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
